// File: rtl/fcp_pkg.sv
// Shared FCP definitions: FSM encoding, frame layout, FIFO geometry and
// register bit positions common to the master and slave engines.
package fcp_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PING = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_BYTE = 3'd3;
    localparam logic [2:0] ST_RSP  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam int unsigned FRAME_UI  = 11;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = 2;
    localparam int unsigned FIFO_CNT_W = 3;

    localparam int unsigned WR_CTL  = 0;
    localparam int unsigned WR_PUSH = 1;
    localparam int unsigned WR_CLR  = 2;

    localparam int unsigned CTL_START = 0;
    localparam int unsigned CTL_PING  = 1;
    localparam int unsigned CTL_INTR  = 2;
    localparam int unsigned CTL_ABORT = 3;

    localparam int unsigned STA_BUSY    = 0;
    localparam int unsigned STA_DONE    = 1;
    localparam int unsigned STA_ACK     = 2;
    localparam int unsigned STA_TO      = 3;
    localparam int unsigned STA_OVF     = 4;
    localparam int unsigned STA_CNT_LSB = 5;

    // Line level for UI index idx of a byte frame: start, d[7:0] MSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [DATA_W-1:0] dat);
        logic b;
        b = STOP_BIT;
        if (idx == 4'd0) begin
            b = START_BIT;
        end else if (idx <= 4'd8) begin
            b = dat[3'(4'd8 - idx)];
        end else if (idx == 4'd9) begin
            b = ~^dat;
        end
        return b;
    endfunction

endpackage

// File: rtl/fcpmst_fifo.sv
// 4x8 TX byte FIFO with occupancy count, flush and an overflow strobe.
module fcpmst_fifo
    import fcp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_wdat,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [DATA_W-1:0]     o_head_c,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic                  o_empty_c,
    output logic                  o_ovf_c
);

    logic [DATA_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    assign w_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign o_empty_c = (r_count == '0);
    assign w_pop     = i_pop && !o_empty_c && !i_flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push    = i_push && !i_flush && (!w_full || w_pop);
    assign o_ovf_c   = i_push && !i_flush && w_full && !w_pop;
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fcpmst.sv
// FCP master transaction engine: optional ping, up to four framed bytes on D-,
// then waits for the slave's response ping and reports done/ack/timeout.
module fcpmst
    import fcp_pkg::*;
#(
    parameter int unsigned UI_CYC     = 1280,
    parameter int unsigned PING_UI    = 16,
    parameter int unsigned GAP_UI     = 2,
    parameter int unsigned RSP_MIN_UI = 8,
    parameter int unsigned RSP_TO_UI  = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_comp,
    input  logic [7:0]  r_wdat,
    input  logic [2:0]  r_wr,
    output logic        tx_en,
    output logic        tx_dat,
    output logic        intr,
    output logic [7:0]  r_ctl,
    output logic [7:0]  r_sta
);

    localparam int unsigned UI_W      = (UI_CYC > 1) ? $clog2(UI_CYC) : 1;
    localparam int unsigned BIT_MAX_A = (PING_UI > GAP_UI) ? PING_UI : GAP_UI;
    localparam int unsigned BIT_MAX_B = (FRAME_UI > RSP_TO_UI) ? FRAME_UI : RSP_TO_UI;
    localparam int unsigned BIT_MAX   = (BIT_MAX_A > BIT_MAX_B) ? BIT_MAX_A : BIT_MAX_B;
    localparam int unsigned BIT_W     = $clog2(BIT_MAX + 1);
    localparam int unsigned LOW_MAX   = RSP_MIN_UI * UI_CYC;
    localparam int unsigned LOW_W     = $clog2(LOW_MAX + 1);

    logic [2:0]            r_state;
    logic [UI_W-1:0]       r_ui;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_W-1:0]     r_dat;
    logic [LOW_W-1:0]      r_low;
    logic                  r_dm_s1;
    logic                  r_dm_s2;
    logic                  r_ping_en;
    logic                  r_intr_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ack;
    logic                  r_to;
    logic                  r_ovf;
    logic                  r_intr;
    logic                  r_tx_en;
    logic                  r_tx_dat;

    logic [2:0]            w_state_nxt;
    logic [UI_W-1:0]       w_ui_nxt;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic [DATA_W-1:0]     w_dat_nxt;
    logic [LOW_W-1:0]      w_low_nxt;
    logic                  w_ctl_wr;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_ui_end;
    logic                  w_enter;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_set_ack;
    logic                  w_set_to;
    logic                  w_set_done;
    logic                  w_ping_en_nxt;
    logic                  w_intr_en_nxt;
    logic                  w_tx_en_nxt;
    logic                  w_tx_dat_nxt;
    logic                  w_clr;
    logic                  w_done_nxt;
    logic                  w_ack_nxt;
    logic                  w_to_nxt;
    logic                  w_ovf_nxt;
    logic                  w_busy_nxt;
    logic                  w_intr_nxt;
    logic [DATA_W-1:0]     w_head;
    logic [FIFO_CNT_W-1:0] w_count;
    logic                  w_empty;
    logic                  w_ovf;

    fcpmst_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (r_wr[WR_PUSH]),
        .i_wdat    (r_wdat),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .o_head_c  (w_head),
        .o_count   (w_count),
        .o_empty_c (w_empty),
        .o_ovf_c   (w_ovf)
    );

    // Next state, UI/bit timing, response detection and next line levels.
    always_comb begin
        w_ctl_wr      = r_wr[WR_CTL];
        w_start       = w_ctl_wr && r_wdat[CTL_START];
        w_abort       = w_ctl_wr && r_wdat[CTL_ABORT];
        w_ping_en_nxt = w_ctl_wr ? r_wdat[CTL_PING] : r_ping_en;
        w_intr_en_nxt = w_ctl_wr ? r_wdat[CTL_INTR] : r_intr_en;
        w_ui_end      = (r_ui == UI_W'(UI_CYC - 1));
        w_state_nxt   = r_state;
        w_ui_nxt      = r_ui;
        w_bit_nxt     = r_bit;
        w_dat_nxt     = r_dat;
        w_low_nxt     = '0;
        w_enter       = 1'b0;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        w_set_ack     = 1'b0;
        w_set_to      = 1'b0;
        w_set_done    = 1'b0;

        if (r_state != ST_IDLE && r_state != ST_DONE) begin
            if (w_ui_end) begin
                w_ui_nxt  = '0;
                w_bit_nxt = r_bit + BIT_W'(1);
            end else begin
                w_ui_nxt  = r_ui + UI_W'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_enter = 1'b1;
                    if (w_ping_en_nxt) begin
                        w_state_nxt = ST_PING;
                    end else if (!w_empty) begin
                        w_state_nxt = ST_BYTE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_PING: begin
                if (w_ui_end && (r_bit == BIT_W'(PING_UI - 1))) begin
                    w_enter     = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_ui_end && (r_bit == BIT_W'(GAP_UI - 1))) begin
                    w_enter     = 1'b1;
                    w_state_nxt = w_empty ? ST_RSP : ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (w_ui_end && (r_bit == BIT_W'(FRAME_UI - 1))) begin
                    w_enter     = 1'b1;
                    w_state_nxt = w_empty ? ST_RSP : ST_BYTE;
                end
            end
            ST_RSP: begin
                // Timeout is counted independently of any low run in progress.
                w_low_nxt = r_dm_s2 ? '0 : r_low + LOW_W'(1);
                if (!r_dm_s2 && (r_low == LOW_W'(LOW_MAX - 1))) begin
                    w_set_ack   = 1'b1;
                    w_enter     = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_ui_end && (r_bit == BIT_W'(RSP_TO_UI - 1))) begin
                    w_set_to    = 1'b1;
                    w_enter     = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_set_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_enter) begin
            w_ui_nxt  = '0;
            w_bit_nxt = '0;
            if (w_state_nxt == ST_BYTE) begin
                w_pop     = 1'b1;
                w_dat_nxt = w_head;
            end
        end

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_ui_nxt    = '0;
            w_bit_nxt   = '0;
            w_low_nxt   = '0;
            w_dat_nxt   = r_dat;
            w_pop       = 1'b0;
            w_flush     = 1'b1;
            w_set_done  = 1'b1;
            w_set_ack   = 1'b0;
            w_set_to    = 1'b0;
        end

        w_tx_en_nxt  = (w_state_nxt == ST_PING) || (w_state_nxt == ST_BYTE);
        w_tx_dat_nxt = 1'b1;
        if (w_state_nxt == ST_PING) begin
            w_tx_dat_nxt = 1'b0;
        end else if (w_state_nxt == ST_BYTE) begin
            w_tx_dat_nxt = frame_bit(4'(w_bit_nxt), w_dat_nxt);
        end
    end

    // Sticky status: a set event beats a same-cycle write-1-clear.
    always_comb begin
        w_clr      = r_wr[WR_CLR];
        w_done_nxt = w_set_done || (r_done && !(w_clr && r_wdat[STA_DONE]));
        w_ack_nxt  = w_set_ack  || (r_ack  && !(w_clr && r_wdat[STA_ACK]));
        w_to_nxt   = w_set_to   || (r_to   && !(w_clr && r_wdat[STA_TO]));
        w_ovf_nxt  = w_ovf      || (r_ovf  && !(w_clr && r_wdat[STA_OVF]));
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_intr_nxt = w_intr_en_nxt && (w_done_nxt || w_to_nxt || w_ovf_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ui      <= '0;
            r_bit     <= '0;
            r_dat     <= '0;
            r_low     <= '0;
            r_dm_s1   <= 1'b1;
            r_dm_s2   <= 1'b1;
            r_ping_en <= 1'b0;
            r_intr_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack     <= 1'b0;
            r_to      <= 1'b0;
            r_ovf     <= 1'b0;
            r_intr    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_dat  <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_ui      <= w_ui_nxt;
            r_bit     <= w_bit_nxt;
            r_dat     <= w_dat_nxt;
            r_low     <= w_low_nxt;
            r_dm_s1   <= dm_comp;
            r_dm_s2   <= r_dm_s1;
            r_ping_en <= w_ping_en_nxt;
            r_intr_en <= w_intr_en_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ack     <= w_ack_nxt;
            r_to      <= w_to_nxt;
            r_ovf     <= w_ovf_nxt;
            r_intr    <= w_intr_nxt;
            r_tx_en   <= w_tx_en_nxt;
            r_tx_dat  <= w_tx_dat_nxt;
        end
    end

    always_comb begin
        r_ctl                                  = '0;
        r_ctl[CTL_PING]                        = r_ping_en;
        r_ctl[CTL_INTR]                        = r_intr_en;
        r_sta                                  = '0;
        r_sta[STA_BUSY]                        = r_busy;
        r_sta[STA_DONE]                        = r_done;
        r_sta[STA_ACK]                         = r_ack;
        r_sta[STA_TO]                          = r_to;
        r_sta[STA_OVF]                         = r_ovf;
        r_sta[STA_CNT_LSB +: FIFO_CNT_W]       = w_count;
    end

    assign tx_en  = r_tx_en;
    assign tx_dat = r_tx_dat;
    assign intr   = r_intr;

endmodule

// File: tb/tb_fcpmst.sv
// Directed bench for fcpmst with a 4-cycle UI; line activity and status are
// compared against hand-derived values.
module tb_fcpmst;

    logic       clk = 1'b0;
    logic       rst;
    logic       dm_comp;
    logic [7:0] r_wdat;
    logic [2:0] r_wr;
    logic       tx_en;
    logic       tx_dat;
    logic       intr;
    logic [7:0] r_ctl;
    logic [7:0] r_sta;

    int n_chk  = 0;
    int n_fail = 0;

    fcpmst #(.UI_CYC(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .dm_comp (dm_comp),
        .r_wdat  (r_wdat),
        .r_wr    (r_wr),
        .tx_en   (tx_en),
        .tx_dat  (tx_dat),
        .intr    (intr),
        .r_ctl   (r_ctl),
        .r_sta   (r_sta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write is sampled on the next posedge, returns at the following negedge.
    task automatic wr(input int idx, input logic [7:0] d);
        r_wr   = 3'(1 << idx);
        r_wdat = d;
        @(negedge clk);
        r_wr   = '0;
        r_wdat = '0;
    endtask

    // Samples 11 UIs x 4 cycles starting at frame cycle 0.
    task automatic chk_frame(input string tag, input logic [7:0] b);
        logic [10:0] fr;
        int          errs;
        logic        exp_bit;
        fr   = {1'b0, b, ~^b, 1'b1};
        errs = 0;
        for (int k = 0; k < 11; k++) begin
            exp_bit = fr[10];
            fr      = fr << 1;
            for (int c = 0; c < 4; c++) begin
                if (tx_en !== 1'b1 || tx_dat !== exp_bit) errs++;
                @(negedge clk);
            end
        end
        chk(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs;
        rst     = 1'b1;
        dm_comp = 1'b1;
        r_wdat  = '0;
        r_wr    = '0;
        step(2);
        chk("rst_line_held", 32'({tx_en, tx_dat, intr}), 32'b010);
        rst = 1'b0;
        step(1);
        chk("rst_sta", 32'(r_sta), 32'h00);
        chk("rst_ctl", 32'(r_ctl), 32'h00);
        chk("rst_line", 32'({tx_en, tx_dat, intr}), 32'b010);

        // Ping + one byte 0x0A, slave answers
        wr(1, 8'h0A);
        chk("t1_cnt", 32'(r_sta), 32'h20);
        wr(0, 8'h07);
        chk("t1_ctl", 32'(r_ctl), 32'h06);
        chk("t1_busy", 32'(r_sta), 32'h21);
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            if (tx_en !== 1'b1 || tx_dat !== 1'b0) errs++;
            step(1);
        end
        chk("t1_ping", 32'(errs), 32'd0);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_en !== 1'b0 || tx_dat !== 1'b1) errs++;
            step(1);
        end
        chk("t1_gap", 32'(errs), 32'd0);
        chk_frame("t1_frame_0A", 8'h0A);
        chk("t1_rsp_sta", 32'(r_sta), 32'h01);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_en !== 1'b0 || tx_dat !== 1'b1) errs++;
            step(1);
        end
        chk("t1_rsp_release", 32'(errs), 32'd0);
        dm_comp = 1'b0;
        n = 0;
        while (!r_sta[2] && n < 300) begin
            step(1);
            n++;
        end
        chk("t1_ack_latency", 32'(n), 32'd34);
        chk("t1_ack_sta", 32'(r_sta), 32'h05);
        step(1);
        chk("t1_done_sta", 32'(r_sta), 32'h06);
        chk("t1_intr", 32'(intr), 32'd1);
        dm_comp = 1'b1;
        wr(2, 8'h1E);
        chk("t1_clear", 32'({intr, r_sta}), 32'h000);

        // No ping, two bytes back to back, no response
        wr(1, 8'h55);
        wr(1, 8'hAA);
        wr(0, 8'h01);
        chk("t2_start_sta", 32'(r_sta), 32'h21);
        chk_frame("t2_frame_55", 8'h55);
        chk_frame("t2_frame_AA", 8'hAA);
        chk("t2_rsp_sta", 32'(r_sta), 32'h01);
        n = 0;
        while (!r_sta[3] && n < 400) begin
            step(1);
            n++;
        end
        chk("t2_timeout_latency", 32'(n), 32'd160);
        chk("t2_to_sta", 32'(r_sta), 32'h09);
        step(1);
        chk("t2_done_sta", 32'(r_sta), 32'h0A);
        chk("t2_intr_off", 32'(intr), 32'd0);
        wr(2, 8'h1E);

        // Overflow: five pushes into a 4-deep FIFO
        wr(0, 8'h04);
        for (int i = 0; i < 5; i++) wr(1, 8'(8'h11 + i));
        chk("t3_ovf_sta", 32'(r_sta), 32'h90);
        chk("t3_ovf_intr", 32'(intr), 32'd1);
        wr(0, 8'h05);
        chk("t3_start_sta", 32'(r_sta), 32'h71);
        chk_frame("t3_frame_11", 8'h11);
        chk_frame("t3_frame_12", 8'h12);
        chk_frame("t3_frame_13", 8'h13);
        chk_frame("t3_frame_14", 8'h14);
        chk("t3_no_5th", 32'({tx_en, r_sta}), 32'h011);
        wr(0, 8'h08);
        chk("t3_abort_sta", 32'(r_sta), 32'h12);
        chk("t3_abort_intr", 32'(intr), 32'd0);
        wr(2, 8'h1E);

        // Abort mid-frame at bit 4
        wr(1, 8'h3C);
        wr(1, 8'h5A);
        wr(0, 8'h01);
        step(17);
        chk("t4_txen_pre", 32'(tx_en), 32'd1);
        wr(0, 8'h08);
        chk("t4_line", 32'({tx_en, tx_dat}), 32'b01);
        chk("t4_sta", 32'(r_sta), 32'h02);
        wr(2, 8'h1E);

        // Start with nothing to do: one DONE cycle, no line activity
        wr(0, 8'h01);
        chk("t5_done_state", 32'({tx_en, r_sta}), 32'h001);
        step(1);
        chk("t5_done_sta", 32'({tx_en, r_sta}), 32'h002);
        wr(2, 8'h1E);

        // Response low run broken by a one-cycle high
        wr(0, 8'h03);
        step(72);
        chk("t6_rsp_release", 32'(tx_en), 32'd0);
        dm_comp = 1'b0;
        step(31);
        dm_comp = 1'b1;
        step(1);
        dm_comp = 1'b0;
        step(2);
        chk("t6_no_early_ack", 32'(r_sta[2]), 32'd0);
        n = 34;
        while (!r_sta[2] && n < 300) begin
            step(1);
            n++;
        end
        chk("t6_ack_latency", 32'(n), 32'd66);
        dm_comp = 1'b1;
        step(1);
        chk("t6_done_sta", 32'(r_sta), 32'h06);
        wr(2, 8'h1E);

        // Reset in the middle of a ping
        wr(1, 8'h77);
        wr(0, 8'h03);
        step(10);
        chk("t7_ping_active", 32'({tx_en, tx_dat}), 32'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_release", 32'({tx_en, tx_dat}), 32'b01);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("t7_sta_cleared", 32'(r_sta), 32'h00);
        chk("t7_ctl_cleared", 32'({intr, r_ctl}), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
